// File: rtl/rf_arb_pkg.sv
// Shared constants and the writeback request record for the register-file write arbiter.
package rf_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'b00000;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant generator: round-robin by default, lowest-index-wins when RF_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

`ifdef RF_ARB_FIXED_PRIO_EN

  // Isolate the lowest set request bit.
  always_comb begin
    grant = '0;
    if (enable && !reset) begin
      grant = req & (~req + {{(NUM_REQ-1){1'b0}}, 1'b1});
    end else begin
      grant = '0;
    end
  end

`else

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic             found;

  function automatic int wrap(input int v);
    return (v >= NUM_REQ) ? (v - NUM_REQ) : v;
  endfunction

  // Search from rr_ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    grant    = '0;
    next_ptr = rr_ptr;
    found    = 1'b0;
    if (enable && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && req[wrap(int'(rr_ptr) + k)]) begin
          found                        = 1'b1;
          grant[wrap(int'(rr_ptr) + k)] = 1'b1;
          next_ptr                     = PTR_W'(wrap(wrap(int'(rr_ptr) + k) + 1));
        end
      end
    end else begin
      grant = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= next_ptr;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources; writes to $zero are consumed and dropped.
// Build option: RF_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority instead of round-robin.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      stall,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic                      RegWrite
);

  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable (~stall),
    .grant  (grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Address/data hold between grants so the register file sees a stable bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_reg  <= '0;
      write_data <= '0;
      RegWrite   <= 1'b0;
    end else if (|grant) begin
      write_reg  <= sel_reg;
      write_data <= sel_data;
      RegWrite   <= (sel_reg != ADDR_W'(ZERO_REG));
    end else begin
      write_reg  <= write_reg;
      write_data <= write_data;
      RegWrite   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (3 requesters); honours RF_ARB_FIXED_PRIO_EN in its reference model.
module tb_regfile_write_arbiter;
  import rf_arb_pkg::*;

  localparam int N = 3;

  typedef struct packed {
    logic    we;
    wr_req_t w;
  } sb_entry_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_reg;
  logic [N*32-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            stall;
  logic [4:0]      write_reg;
  logic [31:0]     write_data;
  logic            RegWrite;

  int checks = 0;
  int errors = 0;

  sb_entry_t   sb[$];
  int          model_ptr = 0;
  logic [4:0]  last_reg  = 5'd0;
  logic [31:0] last_data = 32'd0;
  logic [N-1:0] seen_ready;

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .stall      (stall),
    .write_reg  (write_reg),
    .write_data (write_data),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (!reset && !stall) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      for (int k = N - 1; k >= 0; k--) if (req_valid[k]) g = 3'(1 << k);
`else
      for (int k = N - 1; k >= 0; k--) if (req_valid[(model_ptr + k) % N]) g = 3'(1 << ((model_ptr + k) % N));
`endif
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    req_reg[i*5 +: 5]    = r;
    req_data[i*32 +: 32] = d;
  endtask

  // One clock: check grant, push the expected output, then pop and compare after the edge.
  task automatic step();
    logic [N-1:0] eg;
    sb_entry_t    e;
    #1;
    eg = model_grant();
    seen_ready = req_ready;
    check_eq("req_ready", 32'(req_ready), 32'(eg));
    if (reset) begin
      model_ptr = 0;
      last_reg  = 5'd0;
      last_data = 32'd0;
      e = '{we: 1'b0, w: '{reg_addr: 5'd0, data: 32'd0}};
    end else if (eg != '0) begin
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          last_reg  = req_reg[i*5 +: 5];
          last_data = req_data[i*32 +: 32];
          model_ptr = (i + 1) % N;
        end
      end
      e = '{we: (last_reg != ZERO_REG), w: '{reg_addr: last_reg, data: last_data}};
    end else begin
      e = '{we: 1'b0, w: '{reg_addr: last_reg, data: last_data}};
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("RegWrite", 32'(RegWrite), 32'(e.we));
      check_eq("write_reg", 32'(write_reg), 32'(e.w.reg_addr));
      check_eq("write_data", write_data, e.w.data);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] exp_g;
    reset = 1'b1;
    stall = 1'b0;
    req_valid = 3'b111;
    set_req(0, 5'd3, 32'habcdef12);
    set_req(1, 5'd4, 32'h00000044);
    set_req(2, 5'd5, 32'h00000055);

    // Reset held two cycles with everyone valid.
    step();
    step();
    check_eq("rst_ready", 32'(seen_ready), 32'd0);
    check_eq("rst_we", 32'(RegWrite), 32'd0);
    check_eq("rst_reg", 32'(write_reg), 32'd0);
    check_eq("rst_data", write_data, 32'd0);
    reset = 1'b0;
    req_valid = 3'b001;
    step();
    check_eq("first_grant", 32'(seen_ready), 32'd1);
    check_eq("first_data", write_data, 32'habcdef12);

    // Single write from req1.
    req_valid = 3'b010;
    set_req(1, 5'd7, 32'h12345678);
    step();
    check_eq("single_ready", 32'(seen_ready), 32'd2);
    check_eq("single_we", 32'(RegWrite), 32'd1);
    check_eq("single_reg", 32'(write_reg), 32'd7);
    check_eq("single_data", write_data, 32'h12345678);
    req_valid = 3'b000;
    step();
    check_eq("single_we_drop", 32'(RegWrite), 32'd0);

    // Round-robin from a freshly reset pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'(i));
    for (int k = 0; k < 6; k++) begin
      step();
`ifdef RF_ARB_FIXED_PRIO_EN
      exp_g = 3'b001;
`else
      exp_g = 3'(1 << (k % N));
`endif
      check_eq("rr_seq", 32'(seen_ready), 32'(exp_g));
      check_eq("rr_we", 32'(RegWrite), 32'd1);
    end

    // Write to $zero is consumed but never committed.
    req_valid = 3'b100;
    set_req(2, 5'd0, 32'hffffffff);
    step();
    check_eq("zero_ready", 32'(seen_ready), 32'd4);
    check_eq("zero_we", 32'(RegWrite), 32'd0);
    req_valid = 3'b111;
    set_req(2, 5'd3, 32'h00000002);
    step();
    check_eq("zero_next", 32'(seen_ready), 32'd1);

    // Stall freezes grants and the pointer.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("stall_ready", 32'(seen_ready), 32'd0);
      check_eq("stall_we", 32'(RegWrite), 32'd0);
    end
    stall = 1'b0;
    step();
`ifdef RF_ARB_FIXED_PRIO_EN
    check_eq("stall_resume", 32'(seen_ready), 32'd1);
`else
    check_eq("stall_resume", 32'(seen_ready), 32'd2);
`endif

    // Reset the cycle after a grant to req1.
    req_valid = 3'b010;
    step();
    check_eq("mid_grant", 32'(seen_ready), 32'd2);
    reset = 1'b1;
    req_valid = 3'b111;
    step();
    check_eq("mid_we", 32'(RegWrite), 32'd0);
    check_eq("mid_reg", 32'(write_reg), 32'd0);
    reset = 1'b0;
    step();
    check_eq("mid_next", 32'(seen_ready), 32'd1);

    // Random traffic; payload only changes when the requester is idle or just granted.
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || seen_ready[i]) set_req(i, 5'($urandom_range(0, 31)), $urandom);
      end
      req_valid = 3'($urandom_range(0, 7));
      stall     = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
